// File: rtl/mux_4x1_4bit_rr_if.sv
// rtl/mux_4x1_4bit_rr_if.sv - four-producer collector bus with per-channel and output handshakes
interface mux_4x1_4bit_rr_if;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;
  logic [3:0] d;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [3:0] out;
  logic [1:0] out_sel;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output a, b, c, d, in_valid, out_ready,
    input  in_ready, out, out_sel, out_valid
  );

  modport slave (
    input  a, b, c, d, in_valid, out_ready,
    output in_ready, out, out_sel, out_valid
  );
endinterface

// File: rtl/mux_4x1_4bit_rr.sv
// rtl/mux_4x1_4bit_rr.sv - four-channel 4-bit round-robin collector with registered output
module mux_4x1_4bit_rr (
  input logic              clk,
  input logic              rst,
  mux_4x1_4bit_rr_if.slave bus
);
  logic [3:0] out_q, out_d;
  logic [1:0] out_sel_q, out_sel_d;
  logic       out_valid_q, out_valid_d;
  logic [1:0] ptr_q, ptr_d;

  logic       free;
  logic       gnt_any;
  logic [1:0] gnt_idx;
  logic [1:0] probe;
  logic [3:0] gnt_data;
  logic       accept;

  assign free = !out_valid_q || bus.out_ready;

  // Search starts at ptr; the 2-bit add provides the wrap from d back to a.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    probe   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      probe = ptr_q + 2'(k);
      if (!gnt_any && bus.in_valid[probe]) begin
        gnt_any = 1'b1;
        gnt_idx = probe;
      end
    end
  end

  always_comb begin
    gnt_data = bus.a;
    case (gnt_idx)
      2'd0:    gnt_data = bus.a;
      2'd1:    gnt_data = bus.b;
      2'd2:    gnt_data = bus.c;
      default: gnt_data = bus.d;
    endcase
  end

  assign accept       = free && gnt_any;
  assign bus.in_ready = (accept && !rst) ? (4'b0001 << gnt_idx) : 4'b0000;

  always_comb begin
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_d       = gnt_data;
      out_sel_d   = gnt_idx;
      out_valid_d = 1'b1;
      ptr_d       = gnt_idx + 2'd1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= 4'b0000;
      out_sel_q   <= 2'b00;
      out_valid_q <= 1'b0;
      ptr_q       <= 2'b00;
    end else begin
      out_q       <= out_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_4x1_4bit_rr.sv
// tb/tb_mux_4x1_4bit_rr.sv - directed and randomized scoreboard bench for mux_4x1_4bit_rr
module tb_mux_4x1_4bit_rr;
  logic clk = 1'b0;
  logic rst;

  mux_4x1_4bit_rr_if bus ();

  mux_4x1_4bit_rr dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: output slot plus the channel that has first claim next.
  int         m_ptr;
  logic [3:0] m_out;
  int         m_sel;
  bit         m_vld;

  function automatic logic [3:0] data_of(input int ch);
    case (ch)
      0:       return bus.a;
      1:       return bus.b;
      2:       return bus.c;
      default: return bus.d;
    endcase
  endfunction

  function automatic int m_grant();
    int ch;
    if (m_vld && !bus.out_ready) return -1;
    for (int k = 0; k < 4; k++) begin
      ch = (m_ptr + k) % 4;
      if (bus.in_valid[ch]) return ch;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = m_grant();
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_out = 4'h0;
    m_sel = 0;
    m_vld = 1'b0;
  endtask

  task automatic model_edge();
    int g;
    g = m_grant();
    if (g >= 0) begin
      m_out = data_of(g);
      m_sel = g;
      m_vld = 1'b1;
      m_ptr = (g + 1) % 4;
    end else if (m_vld && bus.out_ready) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_valid"}, 8'(bus.out_valid), 8'(m_vld));
    check_eq({tag, "_out"}, 8'(bus.out), 8'(m_out));
    check_eq({tag, "_sel"}, 8'(bus.out_sel), 8'(m_sel));
  endtask

  // One clock: check in_ready on the driven inputs, advance the model, check registers.
  task automatic step(input string tag);
    #1;
    check_eq({tag, "_in_ready"}, 8'(bus.in_ready), 8'(exp_ready()));
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  // Random producers and scoreboard state
  bit         pv [4];
  logic [3:0] pd [4];
  logic [3:0] fifo [4][$];
  int         waitcnt [4];

  task automatic drive_producers();
    bus.in_valid = {pv[3], pv[2], pv[1], pv[0]};
    bus.a = pd[0];
    bus.b = pd[1];
    bus.c = pd[2];
    bus.d = pd[3];
  endtask

  task automatic rnd_cycle(input bit allow_new);
    logic [3:0] acc;
    int         ch;
    for (int i = 0; i < 4; i++) begin
      if (!pv[i] && allow_new && ($urandom_range(0, 2) != 0)) begin
        pv[i] = 1'b1;
        pd[i] = 4'($urandom);
      end
    end
    drive_producers();
    bus.out_ready = allow_new ? 1'($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    acc = bus.in_ready;
    check_eq("rnd_in_ready", 8'(acc), 8'(exp_ready()));
    check_eq("rnd_onehot", 8'($onehot0(acc)), 8'd1);
    if (bus.out_valid && bus.out_ready) begin
      ch = int'(bus.out_sel);
      if (fifo[ch].size() == 0) check_eq("rnd_unexpected_word", 8'd1, 8'd0);
      else check_eq("rnd_order", 8'(bus.out), 8'(fifo[ch].pop_front()));
    end
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        fifo[i].push_back(pd[i]);
        check_eq("rnd_starve", 8'(waitcnt[i] <= 3), 8'd1);
        waitcnt[i] = 0;
        pv[i] = 1'b0;
      end else if (pv[i] && acc != 4'b0000) begin
        waitcnt[i]++;
      end
    end
    model_edge();
    @(posedge clk);
    #1;
    check_outputs("rnd");
  endtask

  initial begin
    rst = 1'b1;
    bus.a = 4'h0; bus.b = 4'h0; bus.c = 4'h0; bus.d = 4'h0;
    bus.in_valid = 4'b0000;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check_eq("reset_in_ready", 8'(bus.in_ready), 8'd0);
    rst = 1'b0;

    // Round robin with all channels valid
    bus.a = 4'h1; bus.b = 4'h2; bus.c = 4'h3; bus.d = 4'h4;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step("rr");
      check_eq("rr_seq_sel", 8'(bus.out_sel), 8'(i % 4));
      check_eq("rr_seq_out", 8'(bus.out), 8'(i % 4 + 1));
      check_eq("rr_no_bubble", 8'(bus.out_valid), 8'd1);
    end

    // Pointer skip and wrap: c then d leaves ptr at 0
    step("pre_c");
    step("pre_d");
    check_eq("wrap_d", 8'(bus.out_sel), 8'd3);
    bus.in_valid = 4'b0110;
    step("skip");
    check_eq("skip_b", 8'(bus.out_sel), 8'd1);
    bus.in_valid = 4'b1001;
    step("wrap1");
    check_eq("wrap_first_d", 8'(bus.out_sel), 8'd3);
    step("wrap2");
    check_eq("wrap_then_a", 8'(bus.out_sel), 8'd0);

    // Backpressure: load 5 from b, then stall
    bus.b = 4'h5;
    bus.in_valid = 4'b0010;
    step("load_b");
    check_eq("load_b_out", 8'(bus.out), 8'h5);
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      check_eq("stall_out", 8'(bus.out), 8'h5);
      check_eq("stall_sel", 8'(bus.out_sel), 8'd1);
      check_eq("stall_in_ready", 8'(bus.in_ready), 8'd0);
    end
    bus.out_ready = 1'b1;
    step("replace");
    check_eq("replace_sel", 8'(bus.out_sel), 8'd2);
    check_eq("replace_valid", 8'(bus.out_valid), 8'd1);

    // Drain without refill, then confirm ptr stayed at 3
    bus.in_valid = 4'b0000;
    step("drain");
    check_eq("drain_valid", 8'(bus.out_valid), 8'd0);
    check_eq("drain_keep_out", 8'(bus.out), 8'h3);
    bus.in_valid = 4'b1111;
    step("after_drain");
    check_eq("drain_ptr_held", 8'(bus.out_sel), 8'd3);

    // Reset mid-stall
    bus.out_ready = 1'b0;
    step("hold");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("midrst_valid", 8'(bus.out_valid), 8'd0);
    check_eq("midrst_out", 8'(bus.out), 8'd0);
    check_eq("midrst_sel", 8'(bus.out_sel), 8'd0);
    check_eq("midrst_in_ready", 8'(bus.in_ready), 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.c = 4'hA;
    bus.in_valid = 4'b0100;
    step("post_rst");
    check_eq("post_rst_out", 8'(bus.out), 8'hA);
    check_eq("post_rst_sel", 8'(bus.out_sel), 8'd2);

    // Randomized scoreboard
    bus.in_valid = 4'b0000;
    bus.out_ready = 1'b1;
    step("rnd_flush");
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      pd[i] = 4'h0;
      waitcnt[i] = 0;
    end
    for (int n = 0; n < 2000; n++) rnd_cycle(1'b1);
    for (int n = 0; n < 12; n++) rnd_cycle(1'b0);
    for (int i = 0; i < 4; i++) begin
      check_eq("rnd_pending_producer", 8'(pv[i]), 8'd0);
      check_eq("rnd_undelivered", 8'(fifo[i].size()), 8'd0);
    end
    check_eq("rnd_final_valid", 8'(bus.out_valid), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
